writeback: RTL and testbench
============================

// Module: writeback
// PURPOSE
//  In-order writeback/retire stage directly downstream of the exec units (misc, ALU, LSU).
//  Each unit hands over one exec_result tagged with an issue sequence number; results
//  are buffered per unit and retired strictly in sequence order through the single
//  regfile write port. A retiring result with br_valid triggers a one-cycle redirect
//  and pipeline flush.
// PARAMETERS
//  N_UNITS  3  number of exec units feeding this stage
//  SEQ_W    4  sequence-tag width; tags wrap modulo 2**SEQ_W
// PORTS
//  clk           in   1             clock
//  rst           in   1             synchronous, active-high reset
//  flush         in   1             external flush (trap/interrupt)
//  unit_valid    in   N_UNITS       unit i presents a result this cycle
//  unit_seq      in   N_UNITS*SEQ_W sequence tag of unit i's result
//  unit_result   in   N_UNITS*exec_result  rd_idx, rd_val, br_valid, br_target
//  unit_ready    out  N_UNITS       slot i can accept; transfer = valid & ready
//  rf_we         out  1             regfile write enable
//  rf_waddr      out  5             regfile write index
//  rf_wdata      out  32            regfile write data
//  retire_valid  out  1             one instruction retired this cycle
//  retire_seq    out  SEQ_W         tag of the retiring instruction
//  redir_valid   out  1             branch redirect (one-cycle pulse)
//  redir_target  out  32            redirect PC
//  flush_out     out  1             flush to fetch/decode/issue/exec, same cycle as redir_valid
// BEHAVIOUR
//  - Reset: all slots empty, exp_seq=0, every output 0, unit_ready=all-ones in the cycle after reset.
//  - Slot i: one-entry holding register {seq, result}; unit_ready[i] = !slot_valid[i].
//    No bypass: a result transferred in cycle T is retire-eligible from T+1.
//  - Retire (comb. from registers): slot i retires when slot_valid[i] && seq==exp_seq.
//    At most one slot matches (tags unique in flight; assert it). On retire: retire_valid=1,
//    retire_seq=exp_seq, slot cleared at edge, exp_seq<=exp_seq+1 (wraps modulo 2**SEQ_W).
//  - Regfile: rf_we = retire && rd_idx!=0; rf_waddr/rf_wdata from the slot; rf_we=0 otherwise,
//    addr/data then don't-care but hold 0.
//  - Branch: retiring slot with br_valid registers redir_target; redir_valid=flush_out=1 in
//    T+1 for exactly one cycle. At the T edge all slots are cleared and unit inputs presented
//    in T are not captured. The branch's own rd write still happens in T.
//  - In T+1 (redirect cycle): unit_ready=all-ones, inputs ignored (not captured).
//  - External flush: at the edge, all slots cleared, exp_seq unchanged, no retire that cycle
//    (flush overrides retire); issue restarts tagging at exp_seq. No redir_valid.
//  - flush and branch retire in the same cycle: flush wins, no redirect generated.
//  - rst overrides everything, including a pending redirect.
//  - No retire-order timeout; a missing tag stalls retirement indefinitely (issue owns liveness).
// STRUCTURE
//  - types.sv package: seq_t (logic [SEQ_W-1:0]); N_EXEC_UNITS localparam.
//    exec_result is reused unchanged.
//  - Sub-module wb_slot: one holding register with valid/ready, seq compare, and
//    clear-on-retire/flush; instantiated N_UNITS times.
//  - Top level: match-select mux, exp_seq counter, redirect register.
// TESTING
//  - Reset, then unit0 seq0 {rd=5, val=0x1234} -> next cycle rf_we=1, waddr=5, wdata=0x1234,
//    retire_seq=0; exp_seq=1.
//  - Out of order: unit1 seq1 arrives cycle 0, unit0 seq0 arrives cycle 2 -> retire seq0 in
//    cycle 3, seq1 in cycle 4; unit_ready[1]=0 during cycles 1-4.
//  - rd_idx=0 result retires -> retire_valid=1, rf_we=0.
//  - Branch seq2 (br_target=0x80, rd=1, val=0x44) retires in cycle T with seq3 held ->
//    rf write x1=0x44 in T; redir_valid=flush_out=1, target=0x80 in T+1 only; seq3 dropped;
//    exp_seq=3.
//  - Wrap: SEQ_W=4, retire seq 14, 15, 0, 1 back-to-back -> four consecutive retires,
//    exp_seq=2.
//  - External flush with a matching slot -> no retire, slots empty, exp_seq unchanged;
//    flush plus branch retire in the same cycle -> no redir_valid.

Source files
------------

// File: rtl/writeback_pkg.sv
// writeback_pkg: shared types and sizes for the writeback/retire stage
package writeback_pkg;
  localparam int N_EXEC_UNITS = 3;
  localparam int SEQ_W = 4;
  typedef logic [SEQ_W-1:0] seq_t;
  typedef struct packed {
    logic [4:0]  rd_idx;
    logic [31:0] rd_val;
    logic        br_valid;
    logic [31:0] br_target;
  } exec_result;
endpackage

// File: rtl/writeback_if.sv
// writeback_if: exec-unit to writeback result handshake
interface writeback_if;
  import writeback_pkg::*;
  logic       [N_EXEC_UNITS-1:0] unit_valid;
  seq_t       [N_EXEC_UNITS-1:0] unit_seq;
  exec_result [N_EXEC_UNITS-1:0] unit_result;
  logic       [N_EXEC_UNITS-1:0] unit_ready;
  modport master (output unit_valid, unit_seq, unit_result, input unit_ready);
  modport slave (input unit_valid, unit_seq, unit_result, output unit_ready);
endinterface

// File: rtl/writeback_slot.sv
// writeback_slot: one-entry result holding register with in-order tag match
module writeback_slot
  import writeback_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       retire,
  input  logic       in_valid,
  input  seq_t       in_seq,
  input  exec_result in_result,
  input  seq_t       exp_seq,
  output logic       ready,
  output logic       match,
  output exec_result result
);
  logic valid;
  seq_t seq;
  assign ready = !valid;
  assign match = valid && seq == exp_seq;
  // occupancy: cleared by retire or flush/redirect, which also blocks capture
  always_ff @(posedge clk)
    if (rst || clr || retire) valid <= 1'b0;
    else if (in_valid && !valid) valid <= 1'b1;
  // payload captured only on a real transfer into an empty slot
  always_ff @(posedge clk)
    if (rst) begin
      seq    <= '0;
      result <= '0;
    end else if (in_valid && !valid && !clr) begin
      seq    <= in_seq;
      result <= in_result;
    end
endmodule

// File: rtl/writeback.sv
// writeback: in-order retire of buffered exec results with branch redirect
module writeback
  import writeback_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  writeback_if.slave  bus,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        retire_valid,
  output seq_t        retire_seq,
  output logic        redir_valid,
  output logic [31:0] redir_target,
  output logic        flush_out
);
  logic       [N_EXEC_UNITS-1:0] match, grant, ready;
  exec_result [N_EXEC_UNITS-1:0] res;
  exec_result sel;
  seq_t       exp_seq;
  logic       retire, br_take, clr, redir_q;
  logic [31:0] tgt_q;
  assign retire  = |match && !flush;
  assign grant   = flush ? '0 : match;
  assign br_take = retire && sel.br_valid;
  assign clr     = flush || br_take || redir_q;
  assign bus.unit_ready = ready;
  for (genvar g = 0; g < N_EXEC_UNITS; g++) begin : g_slot
    writeback_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .retire    (grant[g]),
      .in_valid  (bus.unit_valid[g]),
      .in_seq    (bus.unit_seq[g]),
      .in_result (bus.unit_result[g]),
      .exp_seq   (exp_seq),
      .ready     (ready[g]),
      .match     (match[g]),
      .result    (res[g])
    );
  end
  // select the single matching slot; zero when nothing matches
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_EXEC_UNITS; i++) sel = match[i] ? res[i] : sel;
  end
  assign retire_valid = retire;
  assign retire_seq   = retire ? exp_seq : '0;
  assign rf_we        = retire && sel.rd_idx != 5'd0;
  assign rf_waddr     = rf_we ? sel.rd_idx : '0;
  assign rf_wdata     = rf_we ? sel.rd_val : '0;
  assign redir_valid  = redir_q;
  assign flush_out    = redir_q;
  assign redir_target = tgt_q;
  // expected tag advances on every retire and wraps naturally
  always_ff @(posedge clk)
    if (rst) exp_seq <= '0;
    else if (retire) exp_seq <= exp_seq + 1'b1;
  // one-cycle redirect pulse after a retiring branch
  always_ff @(posedge clk)
    if (rst) begin
      redir_q <= 1'b0;
      tgt_q   <= '0;
    end else begin
      redir_q <= br_take;
      tgt_q   <= br_take ? sel.br_target : '0;
    end
  a_unique_match: assert property (@(posedge clk) disable iff (rst) $onehot0(match));
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed checks of in-order retire, branch redirect and flush
module tb_writeback;
  import writeback_pkg::*;
  logic        clk = 0, rst = 1, flush = 0;
  logic        rf_we, retire_valid, redir_valid, flush_out;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, redir_target;
  seq_t        retire_seq;
  int          n_checks = 0, n_fails = 0;
  writeback_if bus ();
  writeback dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .retire_valid (retire_valid),
    .retire_seq   (retire_seq),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .flush_out    (flush_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
    bus.unit_valid = '0;
  endtask
  task automatic send(input int u, input seq_t s, input logic [4:0] rd, input logic [31:0] v,
                      input logic br, input logic [31:0] t);
    bus.unit_valid[u]  = 1'b1;
    bus.unit_seq[u]    = s;
    bus.unit_result[u] = '{rd_idx: rd, rd_val: v, br_valid: br, br_target: t};
  endtask
  task automatic check_retire(input string tag, input seq_t s);
    check({tag, "_valid"}, 64'(retire_valid), 64'd1);
    check({tag, "_seq"}, 64'(retire_seq), 64'(s));
  endtask
  initial begin
    bus.unit_valid  = '0;
    bus.unit_seq    = '0;
    bus.unit_result = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    check("rst_ready", 64'(bus.unit_ready), 64'h7);
    check("rst_retire", 64'(retire_valid), 64'd0);
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_redir", 64'({redir_valid, flush_out, redir_target}), 64'd0);
    // basic retire of seq0
    send(0, 4'd0, 5'd5, 32'h1234, 1'b0, 32'h0);
    tick();
    check_retire("basic", 4'd0);
    check("basic_we", 64'(rf_we), 64'd1);
    check("basic_waddr", 64'(rf_waddr), 64'd5);
    check("basic_wdata", 64'(rf_wdata), 64'h1234);
    check("basic_ready", 64'(bus.unit_ready), 64'h6);
    tick();
    check("basic_done", 64'(retire_valid), 64'd0);
    // out of order: seq2 on unit1 first, seq1 on unit0 two cycles later
    send(1, 4'd2, 5'd7, 32'h22, 1'b0, 32'h0);
    tick();
    check("ooo_c1_ready", 64'(bus.unit_ready[1]), 64'd0);
    check("ooo_c1_stall", 64'(retire_valid), 64'd0);
    tick();
    check("ooo_c2_ready", 64'(bus.unit_ready[1]), 64'd0);
    check("ooo_c2_stall", 64'(retire_valid), 64'd0);
    send(0, 4'd1, 5'd6, 32'h11, 1'b0, 32'h0);
    tick();
    check_retire("ooo_c3", 4'd1);
    check("ooo_c3_wdata", 64'(rf_wdata), 64'h11);
    check("ooo_c3_ready", 64'(bus.unit_ready), 64'h4);
    tick();
    check_retire("ooo_c4", 4'd2);
    check("ooo_c4_waddr", 64'(rf_waddr), 64'd7);
    check("ooo_c4_ready", 64'(bus.unit_ready), 64'h5);
    tick();
    check("ooo_c5_idle", 64'(retire_valid), 64'd0);
    check("ooo_c5_ready", 64'(bus.unit_ready), 64'h7);
    // rd_idx 0 retires without a regfile write
    send(2, 4'd3, 5'd0, 32'hdead, 1'b0, 32'h0);
    tick();
    check_retire("x0", 4'd3);
    check("x0_we", 64'(rf_we), 64'd0);
    check("x0_wdata", 64'(rf_wdata), 64'd0);
    tick();
    // branch seq4 retires with seq5 held; seq5 is dropped
    send(0, 4'd4, 5'd1, 32'h44, 1'b1, 32'h80);
    send(1, 4'd5, 5'd9, 32'h55, 1'b0, 32'h0);
    tick();
    check_retire("br_T", 4'd4);
    check("br_T_we", 64'(rf_we), 64'd1);
    check("br_T_waddr", 64'(rf_waddr), 64'd1);
    check("br_T_wdata", 64'(rf_wdata), 64'h44);
    check("br_T_redir", 64'(redir_valid), 64'd0);
    send(2, 4'd6, 5'd2, 32'h66, 1'b0, 32'h0);
    tick();
    check("br_T1_redir", 64'(redir_valid), 64'd1);
    check("br_T1_flush", 64'(flush_out), 64'd1);
    check("br_T1_target", 64'(redir_target), 64'h80);
    check("br_T1_retire", 64'(retire_valid), 64'd0);
    check("br_T1_ready", 64'(bus.unit_ready), 64'h7);
    send(2, 4'd5, 5'd2, 32'h77, 1'b0, 32'h0);
    tick();
    check("br_T2_redir", 64'({redir_valid, flush_out}), 64'd0);
    check("br_T2_retire", 64'(retire_valid), 64'd0);
    check("br_T2_ready", 64'(bus.unit_ready), 64'h7);
    send(1, 4'd5, 5'd9, 32'h55, 1'b0, 32'h0);
    tick();
    check_retire("br_resume", 4'd5);
    tick();
    // march up to the wrap point
    for (int s = 6; s < 14; s++) begin
      send(0, seq_t'(s), 5'd3, 32'(s), 1'b0, 32'h0);
      tick();
      check_retire("walk", seq_t'(s));
      tick();
    end
    // wrap: 14, 15, 0, 1 back-to-back
    send(0, 4'd14, 5'd4, 32'hE, 1'b0, 32'h0);
    send(1, 4'd15, 5'd4, 32'hF, 1'b0, 32'h0);
    send(2, 4'd0, 5'd4, 32'h0, 1'b0, 32'h0);
    tick();
    check_retire("wrap14", 4'd14);
    tick();
    check_retire("wrap15", 4'd15);
    send(0, 4'd1, 5'd4, 32'h1, 1'b0, 32'h0);
    tick();
    check_retire("wrap0", 4'd0);
    tick();
    check_retire("wrap1", 4'd1);
    tick();
    check("wrap_done", 64'(retire_valid), 64'd0);
    // external flush against a matching slot
    send(0, 4'd2, 5'd8, 32'h88, 1'b0, 32'h0);
    tick();
    flush = 1;
    #1;
    check("flush_retire", 64'(retire_valid), 64'd0);
    check("flush_we", 64'(rf_we), 64'd0);
    tick();
    flush = 0;
    #1;
    check("flush_ready", 64'(bus.unit_ready), 64'h7);
    check("flush_after", 64'(retire_valid), 64'd0);
    check("flush_noredir", 64'(redir_valid), 64'd0);
    send(1, 4'd2, 5'd8, 32'h88, 1'b0, 32'h0);
    tick();
    check_retire("flush_resume", 4'd2);
    tick();
    // flush beats a retiring branch
    send(0, 4'd3, 5'd2, 32'h99, 1'b1, 32'h100);
    tick();
    flush = 1;
    #1;
    check("flbr_retire", 64'(retire_valid), 64'd0);
    tick();
    flush = 0;
    #1;
    check("flbr_redir", 64'({redir_valid, flush_out}), 64'd0);
    send(0, 4'd3, 5'd2, 32'h99, 1'b0, 32'h0);
    tick();
    check_retire("flbr_resume", 4'd3);
    tick();
    // reset cancels a pending redirect and restarts tags at 0
    send(0, 4'd4, 5'd3, 32'h5, 1'b1, 32'h200);
    tick();
    check_retire("rstbr_T", 4'd4);
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("rstbr_redir", 64'({redir_valid, flush_out}), 64'd0);
    check("rstbr_target", 64'(redir_target), 64'd0);
    send(2, 4'd0, 5'd1, 32'h1, 1'b0, 32'h0);
    tick();
    check_retire("rst_seq0", 4'd0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
